star_accumulator: RTL and testbench

- Downstream consumer of the exp-multiply stage output stream.
- Receives one scaled `STAR_VECTOR_T` per key/value step over the `vld_in`/`rdy_out` handshake.
- Sums the vectors element-wise with signed saturation over `SEQ_LEN` beats, then presents the finished vector downstream over the `vld_out`/`rdy_in` handshake.
- Closes the per-query accumulation loop between the exp-multiply pipeline and the output normalisation logic.

---
 rtl/star_accumulator.sv | 156 +++++++++++++++
 tb/tb_star_accumulator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/star_accumulator.sv
// star_accumulator
//
// Purpose:
//   Collects SEQ_LEN scaled vectors from the exp-multiply stage and sums them
//   element-wise with signed saturation. The finished vector is then offered
//   to the output normalisation logic. This closes the per-query accumulation
//   loop between those two stages.
//
// Ports:
//   clk         in   single clock, all state changes on the rising edge
//   rst         in   synchronous, active-high reset
//   vld_in      in   upstream beat valid
//   rdy_out     out  accepting a beat this cycle (high in ACCUM only)
//   v_in        in   VEC_LEN packed signed Q9.17 (26-bit) elements, element 0 in the LSBs
//   vld_out     out  accumulated result valid (high in DRAIN only)
//   rdy_in      in   downstream ready
//   v_out       out  accumulator contents, meaningful while vld_out is high
//   beat_count  out  beats accepted so far in the current accumulation
//   sat_flag    out  sticky: some element clamped in the current accumulation
//   fsm_state   out  current FSM state (0 = ACCUM, 1 = DRAIN) for observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data stable until that edge. rdy_out and
// vld_out come straight from the state register, so neither one depends
// combinationally on vld_in or rdy_in. v_out is the accumulator register and
// does not change while vld_out is high and rdy_in is low.

`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 64
`endif
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 63
`endif

module star_accumulator #(
   parameter int SEQ_LEN = `MAX_SEQ_LENGTH,
   parameter int VEC_LEN = `MAX_EMBEDDING_DIM + 1,
   localparam int EW = 26,
   localparam int VW = VEC_LEN * EW,
   localparam int CW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vld_in,
   output logic          rdy_out,
   input  logic [VW-1:0] v_in,
   output logic          vld_out,
   input  logic          rdy_in,
   output logic [VW-1:0] v_out,
   output logic [CW-1:0] beat_count,
   output logic          sat_flag,
   output logic          fsm_state
);

   localparam logic ST_ACCUM = 1'b0;
   localparam logic ST_DRAIN = 1'b1;

   localparam logic [EW-1:0] ELEM_MAX = 26'h1FFFFFF;
   localparam logic [EW-1:0] ELEM_MIN = 26'h2000000;
   localparam logic [CW-1:0] CNT_LAST = CW'(SEQ_LEN - 1);

   logic          state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sat_q, sat_d;
   logic [VW-1:0] acc_q, acc_d;

   logic          beat_accept;
   logic          first_beat;
   logic          last_beat;
   logic [VW-1:0] sum_sat;
   logic [VEC_LEN-1:0] clamp;

   // Per-element saturating add. Each operand is sign-extended to 27 bits,
   // so the sum cannot wrap. When the top two bits differ, the true result
   // lies outside the 26-bit range. In that case bit 26 gives the direction
   // of the overflow.
   for (genvar g = 0; g < VEC_LEN; g++) begin : g_elem
      logic [EW:0] sum_w;

      assign sum_w = {acc_q[g*EW+EW-1], acc_q[g*EW +: EW]}
                   + {v_in[g*EW+EW-1],  v_in[g*EW +: EW]};

      assign clamp[g] = sum_w[EW] ^ sum_w[EW-1];

      assign sum_sat[g*EW +: EW] = !clamp[g] ? sum_w[EW-1:0]
                                 : (sum_w[EW] ? ELEM_MIN : ELEM_MAX);
   end

   assign beat_accept = vld_in && (state_q == ST_ACCUM);
   assign first_beat  = (cnt_q == '0);
   assign last_beat   = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      acc_d   = acc_q;

      case (state_q)
         ST_ACCUM: begin
            if (beat_accept) begin
               // The first beat loads the accumulator directly, so the old
               // result is discarded and no separate clear cycle is needed.
               if (first_beat) begin
                  acc_d = v_in;
                  sat_d = 1'b0;
               end else begin
                  acc_d = sum_sat;
                  sat_d = sat_q | (|clamp);
               end

               if (last_beat) begin
                  cnt_d   = '0;
                  state_d = ST_DRAIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ST_DRAIN: begin
            // The accumulator and sat_flag stay put. The result leaves on the
            // edge where rdy_in is high.
            if (rdy_in) begin
               state_d = ST_ACCUM;
            end
         end

         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACCUM;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         acc_q   <= acc_d;
      end
   end

   assign rdy_out    = (state_q == ST_ACCUM);
   assign vld_out    = (state_q == ST_DRAIN);
   assign v_out      = acc_q;
   assign beat_count = cnt_q;
   assign sat_flag   = sat_q;
   assign fsm_state  = state_q;

endmodule

// File: tb/tb_star_accumulator.sv
module tb_star_accumulator;

   localparam int SEQ_LEN = 4;
   localparam int VEC_LEN = 4;
   localparam int EW      = 26;
   localparam int VW      = VEC_LEN * EW;
   localparam int CW      = 2;
   localparam longint EMAX = 64'sd33554431;
   localparam longint EMIN = -64'sd33554432;

   typedef logic [VW-1:0] vec_t;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          vld_in = 1'b0;
   logic          rdy_in = 1'b1;
   vec_t          v_in = '0;
   logic          rdy_out;
   logic          vld_out;
   vec_t          v_out;
   logic [CW-1:0] beat_count;
   logic          sat_flag;
   logic          fsm_state;

   always #5 clk = ~clk;

   star_accumulator #(.SEQ_LEN(SEQ_LEN), .VEC_LEN(VEC_LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .vld_in     (vld_in),
      .rdy_out    (rdy_out),
      .v_in       (v_in),
      .vld_out    (vld_out),
      .rdy_in     (rdy_in),
      .v_out      (v_out),
      .beat_count (beat_count),
      .sat_flag   (sat_flag),
      .fsm_state  (fsm_state)
   );

   // ---------------- scoreboard state ----------------
   int     errors = 0;
   int     checks = 0;
   vec_t   exp_q[$];
   longint acc_m[VEC_LEN];
   int     model_cnt = 0;
   bit     model_sat = 1'b0;
   bit     last_pending = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t splat(input logic [EW-1:0] e);
      vec_t v;
      for (int i = 0; i < VEC_LEN; i++) v[i*EW +: EW] = e;
      return v;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < VEC_LEN; i++) begin
         if ($urandom_range(0, 3) == 0)
            v[i*EW +: EW] = EW'($urandom);
         else
            v[i*EW +: EW] = EW'(int'($urandom_range(0, 2097152)) - 1048576);
      end
      return v;
   endfunction

   // Reference model: a running sum per element, clamped to the 26-bit signed
   // range after every add. The first beat of a result replaces the sum.
   task automatic model_accept(input vec_t d);
      vec_t r;
      if (model_cnt == 0) model_sat = 1'b0;
      for (int i = 0; i < VEC_LEN; i++) begin
         longint e;
         longint s;
         e = longint'($signed(d[i*EW +: EW]));
         if (model_cnt == 0) begin
            s = e;
         end else begin
            s = acc_m[i] + e;
            if (s > EMAX) begin
               s = EMAX;
               model_sat = 1'b1;
            end else if (s < EMIN) begin
               s = EMIN;
               model_sat = 1'b1;
            end
         end
         acc_m[i] = s;
         r[i*EW +: EW] = s[EW-1:0];
      end
      if (model_cnt == SEQ_LEN - 1) begin
         exp_q.push_back(r);
         last_pending = 1'b1;
         model_cnt = 0;
      end else begin
         model_cnt++;
      end
   endtask

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after the falling edge. At that moment rdy_out
   // already shows what the next rising edge will see.
   task automatic cycle(input bit v, input vec_t d, input bit r, output bit accepted);
      @(negedge clk);
      #1;
      rst    = 1'b0;
      vld_in = v;
      v_in   = d;
      rdy_in = r;
      accepted = v && rdy_out;
      if (accepted) model_accept(d);
   endtask

   task automatic idle(input int n, input int rdy_pct);
      bit a;
      for (int k = 0; k < n; k++) cycle(1'b0, '0, ($urandom_range(0, 99) < rdy_pct), a);
   endtask

   task automatic send_beat(input vec_t d, input int rdy_pct);
      bit a;
      a = 1'b0;
      for (int k = 0; k < 50 && !a; k++) cycle(1'b1, d, ($urandom_range(0, 99) < rdy_pct), a);
      checks++;
      if (!a) begin
         errors++;
         $display("FAIL beat_accept_timeout: got no accept expected accept within 50 cycles at %0t", $time);
      end
   endtask

   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
         rst    = 1'b1;
         vld_in = 1'b0;
         rdy_in = 1'b1;
         model_cnt    = 0;
         model_sat    = 1'b0;
         last_pending = 1'b0;
      end
   endtask

   // Feed four identical-element beats back to back, then look at the result
   // while it sits in DRAIN.
   task automatic feed_splat4(input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                              input logic [EW-1:0] e2, input logic [EW-1:0] e3,
                              input logic [EW-1:0] exp_e, input bit exp_sat, input string tag);
      send_beat(splat(e0), 100);
      send_beat(splat(e1), 100);
      send_beat(splat(e2), 100);
      send_beat(splat(e3), 100);
      @(negedge clk);
      #2;
      check({tag, "_vld"}, 128'(vld_out), 128'(1'b1));
      check({tag, "_value"}, 128'(v_out), 128'(splat(exp_e)));
      check({tag, "_sat"}, 128'(sat_flag), 128'(exp_sat));
   endtask

   // ---------------- monitor ----------------
   bit   exp_drain = 1'b0;
   vec_t held = '0;

   initial begin
      bit new_result;
      forever begin
         @(negedge clk);
         new_result = 1'b0;
         if (rst) begin
            exp_drain    = 1'b0;
            last_pending = 1'b0;
            check("rst_vld_out", 128'(vld_out), 128'(1'b0));
            check("rst_rdy_out", 128'(rdy_out), 128'(1'b1));
            check("rst_beat_count", 128'(beat_count), 128'(0));
            check("rst_sat_flag", 128'(sat_flag), 128'(1'b0));
            check("rst_v_out", 128'(v_out), 128'(0));
         end else begin
            if (exp_drain && rdy_in) exp_drain = 1'b0;
            if (last_pending) begin
               exp_drain    = 1'b1;
               last_pending = 1'b0;
               new_result   = 1'b1;
            end
            check("vld_out", 128'(vld_out), 128'(exp_drain));
            check("rdy_out", 128'(rdy_out), 128'(!exp_drain));
            check("beat_count", 128'(beat_count), 128'(model_cnt));
            check("sat_flag", 128'(sat_flag), 128'(model_sat));
            if (new_result) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL result_unexpected: got vld_out with empty queue expected none at %0t", $time);
               end else begin
                  held = exp_q.pop_front();
                  check("result_v_out", 128'(v_out), 128'(held));
               end
            end else if (exp_drain) begin
               check("drain_hold_v_out", 128'(v_out), 128'(held));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit a;

      // Reset values
      do_reset(2);

      // Basic sum: 1.0 + 1.0 + 0.5 + 0.5 = 3.0
      feed_splat4(26'h20000, 26'h20000, 26'h10000, 26'h10000, 26'h60000, 1'b0, "basic");
      idle(2, 100);

      // Back-pressure: hold rdy_in low for 5 DRAIN cycles while offering a beat
      send_beat(splat(26'h20000), 100);
      send_beat(splat(26'h20000), 100);
      send_beat(splat(26'h10000), 100);
      send_beat(splat(26'h10000), 0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, splat(26'h0AAAA), 1'b0, a);
         check("bp_stall_v_out", 128'(v_out), 128'(splat(26'h60000)));
         check("bp_stall_vld", 128'(vld_out), 128'(1'b1));
         check("bp_not_accepted", 128'(a), 128'(1'b0));
      end
      idle(3, 100);

      // Positive and negative saturation, then the sticky flag clears
      feed_splat4(26'h1800000, 26'h1800000, 26'h1800000, 26'h1800000, 26'h1FFFFFF, 1'b1, "sat_pos");
      idle(1, 100);
      feed_splat4(26'h2800000, 26'h2800000, 26'h2800000, 26'h2800000, 26'h2000000, 1'b1, "sat_neg");
      idle(1, 100);
      send_beat(splat(26'h20000), 100);
      idle(1, 100);
      check("sat_clear_first_beat", 128'(sat_flag), 128'(1'b0));
      send_beat(splat(26'h20000), 100);
      send_beat(splat(26'h20000), 100);
      send_beat(splat(26'h20000), 100);
      idle(2, 100);

      // Bubbles and reload: two results with random gaps
      for (int r = 0; r < 2; r++) begin
         for (int b = 0; b < SEQ_LEN; b++) begin
            idle($urandom_range(0, 3), 50);
            send_beat(rand_vec(), 50);
         end
      end
      idle(4, 100);

      // Reset mid-run discards the partial sum
      send_beat(splat(26'h20000), 100);
      send_beat(splat(26'h20000), 100);
      do_reset(1);
      feed_splat4(26'h20000, 26'h20000, 26'h20000, 26'h20000, 26'h80000, 1'b0, "rst_mid");
      idle(2, 100);

      // Reset in DRAIN
      send_beat(rand_vec(), 100);
      send_beat(rand_vec(), 100);
      send_beat(rand_vec(), 100);
      send_beat(rand_vec(), 0);
      idle(2, 0);
      do_reset(1);
      idle(2, 100);

      // Random soak
      for (int r = 0; r < 15; r++) begin
         for (int b = 0; b < SEQ_LEN; b++) begin
            idle($urandom_range(0, 2), 60);
            send_beat(rand_vec(), 60);
         end
      end
      idle(12, 100);

      check("queue_drained", 128'(exp_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: got no completion expected finish before %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
